// File: rtl/trx_spi_pkg.sv
// Shared types and constants for the transceiver SPI master and the register bank feeding it.
package trx_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_HOLD     = 3'd4,
        ST_GAP      = 3'd5
    } spi_state_e;

    localparam int TRX_FRAME_BITS = 24;
    localparam int TRX_CLK_DIV    = 2;
    localparam int TRX_SS_SETUP   = 2;
    localparam int TRX_SS_HOLD    = 2;
    localparam int TRX_MIN_IDLE   = 2;

    // Transceiver frame layout: R/W flag, 7-bit register address, 16-bit data.
    localparam int TRX_RW_BIT   = 23;
    localparam int TRX_ADDR_MSB = 22;
    localparam int TRX_ADDR_LSB = 16;
    localparam int TRX_DATA_MSB = 15;
    localparam int TRX_DATA_LSB = 0;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/trx_spi_tick.sv
// Loadable down-counter; tc_o marks the last cycle of a loaded interval.
module trx_spi_tick #(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload, or count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A value of L loaded on entry gives a state that lasts exactly L cycles.
    assign tc_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/trx_spi_master.sv
// Mode-0, MSB-first SPI master running one fixed-length transceiver frame per start pulse.
module trx_spi_master
    import trx_spi_pkg::*;
#(
    parameter int N_BITS   = TRX_FRAME_BITS,
    parameter int CLK_DIV  = TRX_CLK_DIV,
    parameter int SS_SETUP = TRX_SS_SETUP,
    parameter int SS_HOLD  = TRX_SS_HOLD,
    parameter int MIN_IDLE = TRX_MIN_IDLE
) (
    input  logic              i_clk,
    input  logic              i_rstb,
    input  logic              i_tx_start,
    input  logic [N_BITS-1:0] i_data_parallel,
    output logic              o_tx_end,
    output logic [N_BITS-1:0] o_data_parallel,
    output logic              o_busy,
    output logic              o_start_err,
    output logic              o_sclk,
    output logic              o_ss,
    output logic              o_mosi,
    input  logic              i_miso
);

    localparam int CNT_W = $clog2(max_of4(CLK_DIV, SS_SETUP, SS_HOLD, MIN_IDLE) + 1);
    localparam int BIT_W = $clog2(N_BITS + 1);

    if ((N_BITS < 8) || (N_BITS > 32) || (CLK_DIV < 1) || (SS_SETUP < 1) ||
        (SS_HOLD < 1) || (MIN_IDLE < 1)) begin : g_param_check
        $error("trx_spi_master: illegal parameter value");
    end

    spi_state_e        state_q;
    logic [N_BITS-1:0] tx_sr_q;
    logic [N_BITS-1:0] rx_sr_q;
    logic [N_BITS-1:0] rdata_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              sclk_q;
    logic              ss_q;
    logic              mosi_q;
    logic              tx_end_q;
    logic              busy_q;
    logic              start_err_q;

    logic              tc_s;
    logic              accept_s;
    logic              load_s;
    logic [CNT_W-1:0]  load_val_s;

    // The final GAP cycle doubles as the IDLE re-entry, so a held start gives exactly MIN_IDLE of SS high.
    assign accept_s = i_tx_start & ((state_q == ST_IDLE) | ((state_q == ST_GAP) & tc_s));

    // Interval reload for whichever state is entered next.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = '0;
        if (accept_s) begin
            load_s     = 1'b1;
            load_val_s = CNT_W'(SS_SETUP);
        end else if (tc_s) begin
            case (state_q)
                ST_SETUP, ST_SHIFT_LO: begin
                    load_s = 1'b1;
                    if (bit_cnt_q < BIT_W'(N_BITS)) begin
                        load_val_s = CNT_W'(CLK_DIV);
                    end else begin
                        load_val_s = CNT_W'(SS_HOLD);
                    end
                end
                ST_SHIFT_HI: begin
                    load_s     = 1'b1;
                    load_val_s = CNT_W'(CLK_DIV);
                end
                ST_HOLD: begin
                    load_s     = 1'b1;
                    load_val_s = CNT_W'(MIN_IDLE);
                end
                default: begin
                    load_s     = 1'b0;
                    load_val_s = '0;
                end
            endcase
        end else begin
            load_s     = 1'b0;
            load_val_s = '0;
        end
    end

    trx_spi_tick #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk_i      (i_clk),
        .rst_ni     (i_rstb),
        .load_i     (load_s),
        .load_val_i (load_val_s),
        .tc_o       (tc_s)
    );

    // Frame sequencer: state, shift registers and every registered pin.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state_q     <= ST_IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rdata_q     <= '0;
            bit_cnt_q   <= '0;
            sclk_q      <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            tx_end_q    <= 1'b0;
            busy_q      <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            tx_end_q    <= 1'b0;
            start_err_q <= i_tx_start & ~accept_s;
            if (accept_s) begin
                state_q   <= ST_SETUP;
                tx_sr_q   <= i_data_parallel;
                mosi_q    <= i_data_parallel[N_BITS-1];
                ss_q      <= 1'b0;
                busy_q    <= 1'b1;
                bit_cnt_q <= '0;
            end else if (tc_s) begin
                case (state_q)
                    ST_SETUP, ST_SHIFT_LO: begin
                        if (bit_cnt_q < BIT_W'(N_BITS)) begin
                            state_q <= ST_SHIFT_HI;
                            sclk_q  <= 1'b1;
                            rx_sr_q <= {rx_sr_q[N_BITS-2:0], i_miso};
                        end else begin
                            state_q <= ST_HOLD;
                        end
                    end
                    ST_SHIFT_HI: begin
                        state_q   <= ST_SHIFT_LO;
                        sclk_q    <= 1'b0;
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        if ((bit_cnt_q + BIT_W'(1)) < BIT_W'(N_BITS)) begin
                            mosi_q  <= tx_sr_q[N_BITS-2];
                            tx_sr_q <= {tx_sr_q[N_BITS-2:0], 1'b0};
                        end
                    end
                    ST_HOLD: begin
                        state_q  <= ST_GAP;
                        ss_q     <= 1'b1;
                        tx_end_q <= 1'b1;
                        rdata_q  <= rx_sr_q;
                        mosi_q   <= 1'b0;
                    end
                    ST_GAP: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        ss_q    <= 1'b1;
                        sclk_q  <= 1'b0;
                        mosi_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_tx_end        = tx_end_q;
    assign o_data_parallel = rdata_q;
    assign o_busy          = busy_q;
    assign o_start_err     = start_err_q;
    assign o_sclk          = sclk_q;
    assign o_ss            = ss_q;
    assign o_mosi          = mosi_q;

endmodule
